// File: rtl/prog_loader.sv
// Serial program loader: receives A5/count/big-endian words over 8N1 UART and writes them to RAM
// port A, holding the CPU in reset until a full image is written. PROG_LOADER_CHECKSUM_EN adds an
// XOR checksum byte after the last word.
module prog_loader #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);
    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StWaitHdr, StGetCnt, StGetHi, StGetLo, StWrite, StGetSum, StDone
    } fr_st_e;
`else
    typedef enum logic [2:0] {StWaitHdr, StGetCnt, StGetHi, StGetLo, StWrite, StDone} fr_st_e;
`endif

    logic              rxd_meta_q, rxd_s_q;
    rx_st_e            rx_st_q, rx_st_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d, rx_byte_q, rx_byte_d;
    logic              rx_valid_q, rx_valid_d, frm_err_q, frm_err_d;
    fr_st_e            fr_q, fr_d;
    logic [8:0]        left_q, left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rx_st_q    <= RxIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            frm_err_q  <= 1'b0;
            fr_q       <= StWaitHdr;
            left_q     <= '0;
            addr_q     <= '0;
            hi_q       <= '0;
            dina_q     <= '0;
            err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rx_st_q    <= rx_st_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            frm_err_q  <= frm_err_d;
            fr_q       <= fr_d;
            left_q     <= left_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            dina_q     <= dina_d;
            err_q      <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // RX bit engine: cnt_q counts clocks within the current bit.
    always_comb begin
        rx_st_d    = rx_st_q;
        cnt_d      = cnt_q + CntW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        frm_err_d  = 1'b0;
        unique case (rx_st_q)
            RxIdle: begin
                cnt_d = '0;
                if (!rxd_s_q) rx_st_d = RxStart;
            end
            RxStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    rx_st_d = rxd_s_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_st_d = RxStop;
                end
            end
            RxStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    rx_st_d = RxIdle;
                    if (rxd_s_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift_q;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: rx_st_d = RxIdle;
        endcase
    end

    always_comb begin
        fr_d   = fr_q;
        left_d = left_q;
        addr_d = addr_q;
        hi_d   = hi_q;
        dina_d = dina_q;
        err_d  = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d  = sum_q;
`endif
        unique case (fr_q)
            StWaitHdr: if (rx_valid_q && rx_byte_q == 8'hA5) fr_d = StGetCnt;
            StGetCnt: begin
                if (rx_valid_q) begin
                    left_d = (rx_byte_q == 8'h00) ? 9'd256 : {1'b0, rx_byte_q};
                    addr_d = '0;
                    fr_d   = StGetHi;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d  = '0;
`endif
                end
            end
            StGetHi: begin
                if (rx_valid_q) begin
                    hi_d = rx_byte_q;
                    fr_d = StGetLo;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d = sum_q ^ rx_byte_q;
`endif
                end
            end
            StGetLo: begin
                if (rx_valid_q) begin
                    dina_d = DATA_W'({hi_q, rx_byte_q});
                    fr_d   = StWrite;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d  = sum_q ^ rx_byte_q;
`endif
                end
            end
            StWrite: begin
                addr_d = addr_q + ADDR_W'(1);
                left_d = left_q - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                fr_d   = (left_q == 9'd1) ? StGetSum : StGetHi;
`else
                fr_d   = (left_q == 9'd1) ? StDone : StGetHi;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            StGetSum: begin
                if (rx_valid_q) begin
                    if (rx_byte_q == sum_q) begin
                        fr_d = StDone;
                    end else begin
                        err_d = 1'b1;
                        fr_d  = StWaitHdr;
                    end
                end
            end
`endif
            StDone: begin
                if (rx_valid_q && rx_byte_q == 8'hA5) begin
                    err_d = 1'b0;
                    fr_d  = StGetCnt;
                end
            end
            default: fr_d = StWaitHdr;
        endcase
        // A running CPU is left alone on line noise; only the sticky flag records it.
        if (frm_err_q) begin
            err_d = 1'b1;
            if (fr_q != StDone) fr_d = StWaitHdr;
        end
    end

    always_comb begin
        ena       = (fr_q == StWrite);
        wea       = (fr_q == StWrite);
        addra     = addr_q;
        dina      = dina_q;
        cpu_hold  = (fr_q != StDone);
        load_done = (fr_q == StDone);
        load_err  = err_q;
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed vector bench for prog_loader at 10 clocks per bit; follows PROG_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        ena, wea, cpu_hold, load_done, load_err;
    logic [7:0]  addra;
    logic [15:0] dina;

    int checks = 0;
    int failures = 0;

    prog_loader #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000),
        .ADDR_W  (8),
        .DATA_W  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int          n;
        logic [63:0] by;
        int          gl;
        int          bad;
        int          nw;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic [7:0]  a1;
        logic [15:0] d1;
        logic        done;
        logic        err;
        logic        hold;
    } vec_t;

    wr_t  wq[$];
    int   cyc = 0, last_we_cyc = 0, done_rise_cyc = 0, multi_cnt = 0, wea_bad = 0;
    logic ena_prev = 1'b0, ld_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ena) begin
            wq.push_back('{a: addra, d: dina});
            last_we_cyc <= cyc;
        end
        if (ena && ena_prev) multi_cnt <= multi_cnt + 1;
        if (wea !== ena) wea_bad <= wea_bad + 1;
        if (load_done && !ld_prev) done_rise_cyc <= cyc;
        ena_prev <= ena;
        ld_prev  <= load_done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rxd = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (10) @(posedge clk);
        end
        rxd = good_stop;
        repeat (10) @(posedge clk);
        rxd = 1'b1;
        if (!good_stop) repeat (20) @(posedge clk);
    endtask

    function automatic vec_t mk(input int n, input logic [63:0] by, input int gl, input int bad,
                                input int nw, input logic [7:0] a0, input logic [15:0] d0,
                                input logic [7:0] a1, input logic [15:0] d1,
                                input logic done, input logic err, input logic hold);
        vec_t v;
        v.n = n; v.by = by; v.gl = gl; v.bad = bad; v.nw = nw;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.done = done; v.err = err; v.hold = hold;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
`ifdef PROG_LOADER_CHECKSUM_EN
        vecs.push_back(mk(7, 64'hA5_02_08_A1_12_34_8F, -1, -1, 2, 8'h00, 16'h08A1, 8'h01, 16'h1234,
                          1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(7, 64'h00_FF_A5_01_BE_EF_51, 2, -1, 1, 8'h00, 16'hBEEF, 8'h00, 16'hBEEF,
                          1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4, 64'hA5_01_BE_EF, -1, 3, 0, 8'h00, 16'h0, 8'h00, 16'h0,
                          1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(5, 64'hA5_01_00_07_07, -1, -1, 1, 8'h00, 16'h0007, 8'h00, 16'h0007,
                          1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(5, 64'hA5_01_12_34_26, -1, -1, 1, 8'h00, 16'h1234, 8'h00, 16'h1234,
                          1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(5, 64'hA5_01_12_34_00, -1, -1, 1, 8'h00, 16'h1234, 8'h00, 16'h1234,
                          1'b0, 1'b1, 1'b1));
`else
        vecs.push_back(mk(6, 64'hA5_02_08_A1_12_34, -1, -1, 2, 8'h00, 16'h08A1, 8'h01, 16'h1234,
                          1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(6, 64'h00_FF_A5_01_BE_EF, 2, -1, 1, 8'h00, 16'hBEEF, 8'h00, 16'hBEEF,
                          1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4, 64'hA5_01_BE_EF, -1, 3, 0, 8'h00, 16'h0, 8'h00, 16'h0,
                          1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(4, 64'hA5_01_00_07, -1, -1, 1, 8'h00, 16'h0007, 8'h00, 16'h0007,
                          1'b1, 1'b1, 1'b0));
`endif

        // Reset values
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ena", ena, 0);
        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_err", load_err, 0);

        // Reset in the middle of the second byte of a word: no write may escape
        wq.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        rxd = 1'b0;
        repeat (35) @(posedge clk);
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("midrst_writes", wq.size(), 0);
        chk("midrst_cpu_hold", cpu_hold, 1);
        chk("midrst_addra", addra, 0);

        for (int v = 0; v < vecs.size(); v++) begin
            wq.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                logic [63:0] by;
                by = vecs[v].by;
                if (i == vecs[v].gl) begin
                    rxd = 1'b0;
                    repeat (3) @(posedge clk);
                    rxd = 1'b1;
                    repeat (20) @(posedge clk);
                end
                send_byte(by[8*(vecs[v].n-1-i) +: 8], i != vecs[v].bad);
            end
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_nwrites", v), wq.size(), vecs[v].nw);
            if (vecs[v].nw > 0 && wq.size() > 0) begin
                chk($sformatf("v%0d_addr0", v), wq[0].a, vecs[v].a0);
                chk($sformatf("v%0d_data0", v), wq[0].d, vecs[v].d0);
                chk($sformatf("v%0d_addrN", v), wq[wq.size()-1].a, vecs[v].a1);
                chk($sformatf("v%0d_dataN", v), wq[wq.size()-1].d, vecs[v].d1);
            end
            chk($sformatf("v%0d_load_done", v), load_done, vecs[v].done);
            chk($sformatf("v%0d_load_err", v), load_err, vecs[v].err);
            chk($sformatf("v%0d_cpu_hold", v), cpu_hold, vecs[v].hold);
`ifndef PROG_LOADER_CHECKSUM_EN
            if (vecs[v].done)
                chk($sformatf("v%0d_release_lat", v), done_rise_cyc - last_we_cyc, 1);
`endif
        end

        // N = 0 loads 256 words and wraps the address back to zero
        wq.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] hb;
            hb = 8'(i);
            send_byte(hb, 1'b1);
            send_byte(~hb, 1'b1);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("wrap_nwrites", wq.size(), 256);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < wq.size() && i < 256; i++) begin
                logic [7:0] hb;
                hb = 8'(i);
                if (wq[i].a !== hb || wq[i].d !== {hb, ~hb}) bad++;
            end
            chk("wrap_contents", bad, 0);
        end
        chk("wrap_load_done", load_done, 1);
        chk("wrap_cpu_hold", cpu_hold, 0);
        chk("wrap_addra", addra, 0);

        chk("ena_single_cycle", multi_cnt, 0);
        chk("wea_eq_ena", wea_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
